mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL expose parameter ADDR_W, default 12, word address width (memory address[13:2]).
REQ-002 The block SHALL expose parameter DATA_W, default 32, data width.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 The block SHALL have ports core_req, core_we, core_addr[ADDR_W], core_wdata[DATA_W], core_mask[2], as inputs: the core data-port command.
REQ-006 The block SHALL have ports core_gnt (1), core_rvalid (1), core_rdata[DATA_W] and core_stall (1), as outputs to the core.
REQ-007 The block SHALL have ports uart_req, uart_we, uart_addr[ADDR_W], uart_wdata[DATA_W], uart_mask[2], as inputs: the UART loader command.
REQ-008 The block SHALL have ports uart_gnt (1), uart_rvalid (1) and uart_rdata[DATA_W], as outputs to the UART loader.
REQ-009 The block SHALL have port boot_mode, input, 1; when high, core requests are never granted.
REQ-010 The block SHALL have ports mem_en (1), mem_str (1), mem_addr[ADDR_W], mem_wdata[DATA_W] and mem_mask[2], all registered outputs to the single-port memory.
REQ-011 The block SHALL have port mem_rdata[DATA_W], input, valid one cycle after the mem_en cycle.

Function
REQ-012 FSM states SHALL be IDLE, ISSUE and CAPTURE; arbitration and gnt SHALL occur only in IDLE.
REQ-013 In IDLE with at least one eligible req, the block SHALL assert exactly one gnt combinationally in that cycle, latch the winner's command and go to ISSUE.
REQ-014 Eligibility: uart_req is always eligible; core_req is eligible only when boot_mode is 0.
REQ-015 With both eligible, the winner SHALL be the requester not granted most recently (2-way round-robin); last_owner updates on every grant.
REQ-016 In ISSUE, mem_en SHALL be 1 and mem_addr/mem_wdata/mem_mask/mem_str SHALL equal the latched command; mem_str = latched we.
REQ-017 A write SHALL go from ISSUE to IDLE (2 cycles per write); a read SHALL go from ISSUE to CAPTURE.
REQ-018 In CAPTURE, mem_rdata SHALL be registered into the owner's rdata, and that owner's rvalid SHALL pulse high for exactly the following cycle; next state is IDLE.
REQ-019 Read latency SHALL be gnt in cycle N, rvalid in cycle N+3; a new gnt MAY occur in cycle N+3.
REQ-020 The rdata outputs SHALL hold their value until the next read completes for that same requester.
REQ-021 Outside ISSUE, mem_en and mem_str SHALL be 0; mem_addr, mem_wdata and mem_mask hold their last value.
REQ-022 core_stall SHALL equal core_req AND NOT core_gnt, and SHALL also be high from core gnt until the core read's rvalid.
REQ-023 A requester SHALL hold req and command stable until its gnt; after gnt, req is re-evaluated as a new request.
REQ-024 The mask SHALL pass through unmodified; the block SHALL NOT interpret it.
REQ-025 A change of boot_mode mid-transaction SHALL NOT abort an in-flight core access.

Reset
REQ-026 On reset=1 at a clock edge, the block SHALL enter state IDLE, clear all outputs to 0 (including rdata), and set last_owner = UART so that the core wins the first tie.
REQ-027 A reset during ISSUE or CAPTURE SHALL cancel the access with no rvalid; mem_en=0 and mem_str=0 from the next cycle.
REQ-028 While reset is high, no gnt SHALL assert.

Structure
REQ-029 Package mem_arbiter_pkg SHALL hold the state enum, the owner encoding (OWN_CORE, OWN_UART) and the ADDR_W/DATA_W defaults.
REQ-030 The round-robin pick SHALL be a sub-module rr_arb2 (inputs req[2], last_owner; output one-hot gnt[2]); the FSM and registers stay in mem_arbiter.

Verification
REQ-031 Core read, addr 0x010, memory word 0xDEADBEEF: core_gnt at N, mem_en at N+1 with addr 0x010, core_rvalid at N+3 with core_rdata 0xDEADBEEF.
REQ-032 Simultaneous core and UART writes, three times back-to-back after reset: grant order is core, uart, core, one gnt every 2 cycles, with mem_str=1 in each ISSUE.
REQ-033 boot_mode=1, core_req held and UART writes 4 words: only uart_gnt asserts, and core_stall stays 1 throughout; after boot_mode=0, core is granted on the next IDLE.
REQ-034 Reset asserted in the CAPTURE cycle of a UART read: no uart_rvalid, uart_rdata=0, state IDLE on the next cycle, and the next tie goes to core.
REQ-035 UART write 0x12345678 with mask 2'b10 to 0xFFF (address wrap boundary): mem_addr 0xFFF, mem_mask 2'b10, mem_wdata 0x12345678; a subsequent read of 0xFFF returns the memory model's value.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-port memory arbiter: FSM states,
// owner encoding and default bus widths.
package mem_arbiter_pkg;

  localparam int ADDR_W_DEF = 12;
  localparam int DATA_W_DEF = 32;

  // Arbiter FSM: arbitration only happens in ST_IDLE
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2
  } state_t;

  // Owner encoding; the value doubles as the requester's bit index
  localparam logic OWN_CORE = 1'b0;
  localparam logic OWN_UART = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick. req[0] is the core, req[1] the UART.
// On a tie the requester that was NOT granted most recently wins.
module rr_arb2
  import mem_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_owner,
  output logic [1:0] gnt
);

  // One-hot pick; a lone requester always wins
  always_comb begin
    gnt = 2'b00;
    if (req[0] && req[1]) begin
      if (last_owner == OWN_UART) begin
        gnt = 2'b01;
      end else begin
        gnt = 2'b10;
      end
    end else begin
      gnt = req;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter between the core data port and the UART loader in front of a
// single-port synchronous memory. One access at a time: grant in IDLE,
// drive the memory in ISSUE, and for reads return data from CAPTURE.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  input  logic [1:0]        core_mask,
  output logic              core_gnt,
  output logic              core_rvalid,
  output logic [DATA_W-1:0] core_rdata,
  output logic              core_stall,
  input  logic              uart_req,
  input  logic              uart_we,
  input  logic [ADDR_W-1:0] uart_addr,
  input  logic [DATA_W-1:0] uart_wdata,
  input  logic [1:0]        uart_mask,
  output logic              uart_gnt,
  output logic              uart_rvalid,
  output logic [DATA_W-1:0] uart_rdata,
  input  logic              boot_mode,
  output logic              mem_en,
  output logic              mem_str,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [1:0]        mem_mask,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_t state_reg;
  logic   owner_reg;
  logic   last_owner_reg;
  logic   we_reg;

  logic [1:0]        eligible;
  logic [1:0]        arb_gnt;
  logic              grant_any;
  logic              win_owner;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [1:0]        sel_mask;
  logic              core_rd_busy;

  // Requests only compete in IDLE and never while reset is held;
  // boot_mode locks the core out so the loader owns the memory.
  assign eligible = (state_reg == ST_IDLE && !reset)
                  ? {uart_req, core_req & ~boot_mode}
                  : 2'b00;

  rr_arb2 u_rr_arb2 (
    .req        (eligible),
    .last_owner (last_owner_reg),
    .gnt        (arb_gnt)
  );

  assign core_gnt  = arb_gnt[0];
  assign uart_gnt  = arb_gnt[1];
  assign grant_any = |arb_gnt;
  assign win_owner = arb_gnt[1] ? OWN_UART : OWN_CORE;

  assign sel_we    = arb_gnt[1] ? uart_we    : core_we;
  assign sel_addr  = arb_gnt[1] ? uart_addr  : core_addr;
  assign sel_wdata = arb_gnt[1] ? uart_wdata : core_wdata;
  assign sel_mask  = arb_gnt[1] ? uart_mask  : core_mask;

  // A granted core read keeps the core stalled until its data returns
  assign core_rd_busy = (state_reg != ST_IDLE) && (owner_reg == OWN_CORE) && !we_reg;
  assign core_stall   = !reset && ((core_req && !core_gnt) ||
                                   (core_gnt && !core_we) ||
                                   core_rd_busy);

  // FSM plus the registered memory command; the command is loaded on the
  // grant edge so it is on the memory pins during ISSUE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= ST_IDLE;
      owner_reg      <= OWN_CORE;
      last_owner_reg <= OWN_UART;
      we_reg         <= 1'b0;
      mem_en         <= 1'b0;
      mem_str        <= 1'b0;
      mem_addr       <= '0;
      mem_wdata      <= '0;
      mem_mask       <= '0;
    end else begin
      mem_en  <= 1'b0;
      mem_str <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (grant_any) begin
            state_reg      <= ST_ISSUE;
            owner_reg      <= win_owner;
            last_owner_reg <= win_owner;
            we_reg         <= sel_we;
            mem_en         <= 1'b1;
            mem_str        <= sel_we;
            mem_addr       <= sel_addr;
            mem_wdata      <= sel_wdata;
            mem_mask       <= sel_mask;
          end
        end
        ST_ISSUE: begin
          state_reg <= we_reg ? ST_IDLE : ST_CAPTURE;
        end
        ST_CAPTURE: begin
          state_reg <= ST_IDLE;
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  // Per-requester read return path; index gi matches the owner encoding
  for (genvar gi = 0; gi < 2; gi++) begin : g_ret
    localparam logic OWNER = (gi == 0) ? OWN_CORE : OWN_UART;
    logic [DATA_W-1:0] rdata_reg;
    logic              rvalid_reg;

    // Capture memory data in CAPTURE and hold it until this owner's next read
    always_ff @(posedge clk) begin
      if (reset) begin
        rdata_reg  <= '0;
        rvalid_reg <= 1'b0;
      end else begin
        rvalid_reg <= (state_reg == ST_CAPTURE) && (owner_reg == OWNER);
        if ((state_reg == ST_CAPTURE) && (owner_reg == OWNER)) begin
          rdata_reg <= mem_rdata;
        end
      end
    end
  end

  assign core_rdata  = g_ret[0].rdata_reg;
  assign core_rvalid = g_ret[0].rvalid_reg;
  assign uart_rdata  = g_ret[1].rdata_reg;
  assign uart_rvalid = g_ret[1].rvalid_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios followed by randomized
// traffic, checked against a transaction-level model of the arbiter and
// a reference copy of memory contents.
module tb_mem_arbiter;

  typedef struct {
    bit          pend;
    bit          we;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [1:0]  mask;
  } cmd_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        core_req, core_we, core_gnt, core_rvalid, core_stall;
  logic [11:0] core_addr;
  logic [31:0] core_wdata, core_rdata;
  logic [1:0]  core_mask;
  logic        uart_req, uart_we, uart_gnt, uart_rvalid;
  logic [11:0] uart_addr;
  logic [31:0] uart_wdata, uart_rdata;
  logic [1:0]  uart_mask;
  logic        boot_mode;
  logic        mem_en, mem_str;
  logic [11:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic [1:0]  mem_mask;

  int tests = 0;
  int fails = 0;

  cmd_t        c_cmd, u_cmd;
  bit          boot;
  bit          flip_boot;
  bit          m_last_uart;
  bit          last_win_u;
  logic [31:0] exp_c_rdata, exp_u_rdata;
  logic [31:0] exp_mem [0:4095];
  logic [31:0] mem_model [0:4095];
  logic        mem_load;

  mem_arbiter #(.ADDR_W(12), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_mask(core_mask),
    .core_gnt(core_gnt), .core_rvalid(core_rvalid), .core_rdata(core_rdata),
    .core_stall(core_stall),
    .uart_req(uart_req), .uart_we(uart_we), .uart_addr(uart_addr),
    .uart_wdata(uart_wdata), .uart_mask(uart_mask),
    .uart_gnt(uart_gnt), .uart_rvalid(uart_rvalid), .uart_rdata(uart_rdata),
    .boot_mode(boot_mode),
    .mem_en(mem_en), .mem_str(mem_str), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_mask(mem_mask), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int i);
    if (i == 16) return 32'hDEADBEEF;
    return 32'hA5C3_0000 ^ (32'(i) * 32'h0100_0193);
  endfunction

  // Single-port memory: mask bit 0 enables the low half-word, bit 1 the high
  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 4096; i++) mem_model[i] <= init_word(i);
    end else if (mem_en) begin
      if (mem_str) begin
        if (mem_mask[0]) mem_model[mem_addr][15:0]  <= mem_wdata[15:0];
        if (mem_mask[1]) mem_model[mem_addr][31:16] <= mem_wdata[31:16];
      end else begin
        mem_rdata <= mem_model[mem_addr];
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  function automatic cmd_t mk_cmd(input bit pend, input bit we, input logic [11:0] a,
                                  input logic [31:0] d, input logic [1:0] m);
    cmd_t c;
    c.pend = pend; c.we = we; c.addr = a; c.wdata = d; c.mask = m;
    return c;
  endfunction

  function automatic cmd_t rand_cmd();
    logic [11:0] a;
    a = ($urandom_range(0, 1) == 0) ? 12'($urandom_range(0, 7)) : 12'($urandom());
    return mk_cmd(1'b1, 1'($urandom_range(0, 1)), a, $urandom(), 2'($urandom()));
  endfunction

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drive_inputs();
    core_req = c_cmd.pend; core_we = c_cmd.we; core_addr = c_cmd.addr;
    core_wdata = c_cmd.wdata; core_mask = c_cmd.mask;
    uart_req = u_cmd.pend; uart_we = u_cmd.we; uart_addr = u_cmd.addr;
    uart_wdata = u_cmd.wdata; uart_mask = u_cmd.mask;
    boot_mode = boot;
  endtask

  task automatic model_reset();
    m_last_uart = 1'b1;
    exp_c_rdata = '0;
    exp_u_rdata = '0;
  endtask

  // Hold reset for a few cycles with both sides requesting
  task automatic do_reset();
    reset = 1'b1;
    drive_inputs();
    for (int i = 0; i < 3; i++) begin
      step();
      #1;
      chk("rst_core_gnt", 64'(core_gnt), 64'(0));
      chk("rst_uart_gnt", 64'(uart_gnt), 64'(0));
      chk("rst_mem_en", 64'(mem_en), 64'(0));
      chk("rst_mem_addr", 64'(mem_addr), 64'(0));
      chk("rst_rdata", 64'({core_rdata, uart_rdata}), 64'(0));
      chk("rst_stall", 64'(core_stall), 64'(0));
    end
    reset = 1'b0;
    model_reset();
  endtask

  // One arbitration opportunity starting in an IDLE cycle; for a granted
  // access it follows the transaction to completion and checks each cycle.
  task automatic run_slot();
    bit          c_el, u_el, win_u, crd;
    cmd_t        w;
    logic [31:0] rd;
    drive_inputs();
    #1;
    chk("idle_mem_en", 64'(mem_en), 64'(0));
    c_el = c_cmd.pend && !boot;
    u_el = u_cmd.pend;
    if (!c_el && !u_el) begin
      chk("none_core_gnt", 64'(core_gnt), 64'(0));
      chk("none_uart_gnt", 64'(uart_gnt), 64'(0));
      chk("none_stall", 64'(core_stall), 64'(c_cmd.pend));
      step();
      return;
    end
    win_u = (c_el && u_el) ? !m_last_uart : u_el;
    w     = win_u ? u_cmd : c_cmd;
    crd   = !win_u && !w.we;
    chk("gnt_core", 64'(core_gnt), 64'(!win_u));
    chk("gnt_uart", 64'(uart_gnt), 64'(win_u));
    chk("gnt_stall", 64'(core_stall), 64'((c_cmd.pend && win_u) || crd));
    m_last_uart = win_u;
    last_win_u  = win_u;
    if (win_u) u_cmd.pend = 1'b0; else c_cmd.pend = 1'b0;
    if (flip_boot) boot = 1'($urandom_range(0, 1));

    step();
    drive_inputs();
    #1;
    chk("iss_en", 64'(mem_en), 64'(1));
    chk("iss_str", 64'(mem_str), 64'(w.we));
    chk("iss_addr", 64'(mem_addr), 64'(w.addr));
    chk("iss_wdata", 64'(mem_wdata), 64'(w.wdata));
    chk("iss_mask", 64'(mem_mask), 64'(w.mask));
    chk("iss_gnt", 64'({core_gnt, uart_gnt}), 64'(0));
    chk("iss_rvalid", 64'({core_rvalid, uart_rvalid}), 64'(0));
    chk("iss_stall", 64'(core_stall), 64'(c_cmd.pend || crd));
    if (w.we) begin
      if (w.mask[0]) exp_mem[w.addr][15:0]  = w.wdata[15:0];
      if (w.mask[1]) exp_mem[w.addr][31:16] = w.wdata[31:16];
      step();
      return;
    end

    step();
    #1;
    chk("cap_en", 64'({mem_en, mem_str}), 64'(0));
    chk("cap_addr_hold", 64'(mem_addr), 64'(w.addr));
    chk("cap_gnt", 64'({core_gnt, uart_gnt}), 64'(0));
    chk("cap_rvalid", 64'({core_rvalid, uart_rvalid}), 64'(0));
    chk("cap_stall", 64'(core_stall), 64'(c_cmd.pend || crd));

    step();
    #1;
    rd = exp_mem[w.addr];
    if (win_u) exp_u_rdata = rd; else exp_c_rdata = rd;
    chk("rv_core", 64'(core_rvalid), 64'(!win_u));
    chk("rv_uart", 64'(uart_rvalid), 64'(win_u));
    chk("rdata_core", 64'(core_rdata), 64'(exp_c_rdata));
    chk("rdata_uart", 64'(uart_rdata), 64'(exp_u_rdata));
  endtask

  initial begin
    logic [31:0] w_fff;
    for (int i = 0; i < 4096; i++) exp_mem[i] = init_word(i);
    flip_boot  = 1'b0;
    boot       = 1'b0;
    last_win_u = 1'b0;
    mem_load   = 1'b1;
    c_cmd = mk_cmd(1'b1, 1'b0, 12'h010, 32'h0, 2'b00);
    u_cmd = mk_cmd(1'b1, 1'b1, 12'h100, 32'h1111_2222, 2'b11);
    reset = 1'b1;
    drive_inputs();
    step();
    mem_load = 1'b0;
    do_reset();

    // Core read of 0x010 holding 0xDEADBEEF
    c_cmd = mk_cmd(1'b1, 1'b0, 12'h010, 32'h0, 2'b00);
    u_cmd.pend = 1'b0;
    run_slot();
    chk("req031_rdata", 64'(core_rdata), 64'(32'hDEADBEEF));

    // Three back-to-back write ties after reset: core, uart, core
    do_reset();
    c_cmd = mk_cmd(1'b1, 1'b1, 12'h020, 32'hC0DE_0001, 2'b11);
    u_cmd = mk_cmd(1'b1, 1'b1, 12'h021, 32'hBEEF_0002, 2'b11);
    run_slot();
    chk("req032_first", 64'(last_win_u), 64'(0));
    c_cmd = mk_cmd(1'b1, 1'b1, 12'h022, 32'hC0DE_0003, 2'b01);
    run_slot();
    chk("req032_second", 64'(last_win_u), 64'(1));
    u_cmd = mk_cmd(1'b1, 1'b1, 12'h023, 32'hBEEF_0004, 2'b10);
    run_slot();
    chk("req032_third", 64'(last_win_u), 64'(0));

    // Boot mode: core read held off while the loader writes 4 words
    boot  = 1'b1;
    c_cmd = mk_cmd(1'b1, 1'b0, 12'h021, 32'h0, 2'b00);
    for (int i = 0; i < 4; i++) begin
      u_cmd = mk_cmd(1'b1, 1'b1, 12'(12'h040 + i), 32'(32'h5000_0000 + i), 2'b11);
      run_slot();
      chk("req033_uart_only", 64'(last_win_u), 64'(1));
    end
    boot = 1'b0;
    run_slot();
    chk("req033_core_after", 64'(last_win_u), 64'(0));

    // Boundary address write with partial mask, then read back
    u_cmd = mk_cmd(1'b1, 1'b1, 12'hFFF, 32'h1234_5678, 2'b10);
    run_slot();
    u_cmd = mk_cmd(1'b1, 1'b0, 12'hFFF, 32'h0, 2'b00);
    run_slot();
    w_fff = init_word(4095);
    chk("req035_rdata", 64'(uart_rdata), 64'({16'h1234, w_fff[15:0]}));

    // Reset landing in the CAPTURE cycle of a UART read
    u_cmd = mk_cmd(1'b1, 1'b0, 12'h005, 32'h0, 2'b00);
    drive_inputs();
    #1;
    chk("req034_gnt", 64'(uart_gnt), 64'(1));
    u_cmd.pend = 1'b0;
    step();
    drive_inputs();
    #1;
    chk("req034_issue", 64'(mem_en), 64'(1));
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    model_reset();
    #1;
    chk("req034_no_rvalid", 64'(uart_rvalid), 64'(0));
    chk("req034_rdata", 64'(uart_rdata), 64'(0));
    chk("req034_mem_en", 64'({mem_en, mem_str}), 64'(0));
    c_cmd = mk_cmd(1'b1, 1'b1, 12'h030, 32'hAAAA_5555, 2'b11);
    u_cmd = mk_cmd(1'b1, 1'b1, 12'h031, 32'h5555_AAAA, 2'b11);
    run_slot();
    chk("req034_core_tie", 64'(last_win_u), 64'(0));

    // Randomized traffic, boot_mode may flip mid-transaction
    flip_boot = 1'b1;
    for (int k = 0; k < 200; k++) begin
      if (!c_cmd.pend && $urandom_range(0, 1) == 1) c_cmd = rand_cmd();
      if (!u_cmd.pend && $urandom_range(0, 2) != 0) u_cmd = rand_cmd();
      boot = ($urandom_range(0, 3) == 0);
      run_slot();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
